// File: rtl/window_scanner_pkg.sv
// Shared CNN-layer definitions: scanner FSM encoding, default frame geometry,
// the window payload carried to the address-offset stage, and the 3x3 tap offsets.
package window_scanner_pkg;

    localparam int unsigned ADDR_W         = 13;
    localparam int unsigned DEFAULT_WIDTH  = 80;
    localparam int unsigned DEFAULT_HEIGHT = 60;

    // Scanner FSM encoding
    localparam int unsigned STATE_W = 2;
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_SCAN = 2'd1;
    localparam logic [1:0]  ST_DONE = 2'd2;

    // Number of taps in a 3x3 window
    localparam int unsigned WIN_TAPS = 9;

    // Window descriptor handed downstream
    typedef struct packed {
        logic [ADDR_W-1:0] reference;
        logic [ADDR_W-1:0] out_index;
        logic              last;
    } window_t;

    // Offset of tap (0..8, row-major) from the window's top-left pixel.
    // Evaluated with constant width by the offset stage, so no runtime multiplier.
    function automatic logic [ADDR_W-1:0] win_offset(input int unsigned tap,
                                                     input int unsigned width);
        return ADDR_W'((tap / 3) * width + (tap % 3));
    endfunction

endpackage

// File: rtl/window_scanner.sv
// window_scanner: walks every valid 3x3 window of a WIDTHxHEIGHT frame in
// raster order, emitting the top-left pixel address and the linear output index.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   start, abort    - begin a scan (IDLE only) / drop back to IDLE
//   ready           - downstream accepts the current window
//   reference       - top-left pixel address of the current window
//   out_index       - linear index of the convolution result
//   valid, last     - window valid / final window of the frame
//   busy, done      - not idle / one-cycle frame-complete pulse
module window_scanner
    import window_scanner_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned HEIGHT = DEFAULT_HEIGHT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [12:0] reference,
    output logic [12:0] out_index,
    output logic        valid,
    input  logic        ready,
    output logic        last,
    output logic        busy,
    output logic        done
);

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 3);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 3);

    logic [STATE_W-1:0] state_q, state_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    window_t            win_q, win_d;

    // Next-state and incremental address generation
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        win_d   = win_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d         = ST_SCAN;
                    x_d             = '0;
                    y_d             = '0;
                    win_d.reference = '0;
                    win_d.out_index = '0;
                end
            end
            ST_SCAN: begin
                if (valid && ready) begin
                    if (win_q.last) begin
                        state_d = ST_DONE;
                    end else if (x_q != X_LAST) begin
                        x_d             = x_q + XW'(1);
                        win_d.reference = win_q.reference + ADDR_W'(1);
                        win_d.out_index = win_q.out_index + ADDR_W'(1);
                    end else begin
                        // Row wrap: step over the two right-edge columns
                        x_d             = '0;
                        y_d             = y_q + YW'(1);
                        win_d.reference = win_q.reference + ADDR_W'(3);
                        win_d.out_index = win_q.out_index + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort beats start and any simultaneous transfer
        if (abort) begin
            state_d         = ST_IDLE;
            x_d             = '0;
            y_d             = '0;
            win_d.reference = '0;
            win_d.out_index = '0;
        end

        win_d.last = (state_d == ST_SCAN) && (x_d == X_LAST) && (y_d == Y_LAST);
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            win_q   <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            win_q   <= win_d;
            valid   <= (state_d == ST_SCAN);
            busy    <= (state_d != ST_IDLE);
            done    <= (state_d == ST_DONE);
        end
    end

    assign reference = win_q.reference;
    assign out_index = win_q.out_index;
    assign last      = win_q.last;

endmodule

// File: doc/window_scanner.md
WINDOW_SCANNER -- requirements
Module: window_scanner

Interface
REQ-001 The block SHALL have parameter WIDTH, default 80, meaning image width in pixels.
REQ-002 The block SHALL have parameter HEIGHT, default 60, meaning image height in pixels.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin a frame scan; honoured only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: terminate the scan and return to IDLE.
REQ-007 The block SHALL have port reference, output, 13 bits: top-left pixel address of the current 3x3 window, fed to the address-offset stage.
REQ-008 The block SHALL have port out_index, output, 13 bits: linear index of the convolution result, y*(WIDTH-2)+x.
REQ-009 The block SHALL have port valid, output, 1 bit: reference and out_index hold a valid window.
REQ-010 The block SHALL have port ready, input, 1 bit: downstream accepts the window this cycle.
REQ-011 The block SHALL have port last, output, 1 bit: the current window is the final window of the frame.
REQ-012 The block SHALL have port busy, output, 1 bit: high while not in IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-014 The FSM SHALL have three states: IDLE, SCAN, DONE.
REQ-015 IDLE->SCAN SHALL occur on start=1, with x=0, y=0, reference=0, out_index=0.
REQ-016 valid SHALL be 1 exactly in SCAN and SHALL assert the cycle after start is sampled.
REQ-017 A transfer SHALL occur on valid&ready; reference, out_index and last SHALL stay stable while valid=1 and ready=0.
REQ-018 On a transfer with x<WIDTH-3: x+=1, reference+=1, out_index+=1.
REQ-019 On a transfer with x=WIDTH-3 and y<HEIGHT-3: x=0, y+=1, reference+=3 (skip 2 edge columns), out_index+=1.
REQ-020 The address computation SHALL be incremental; the block SHALL NOT use a multiplier.
REQ-021 last SHALL be 1 in SCAN iff x=WIDTH-3 and y=HEIGHT-3.
REQ-022 A transfer with last=1 SHALL move the FSM to DONE; done=1 for exactly that DONE cycle, after which the FSM SHALL return to IDLE.
REQ-023 A frame SHALL produce exactly (WIDTH-2)*(HEIGHT-2) transfers: 4524 at the default parameters.
REQ-024 start SHALL be ignored in SCAN and DONE.
REQ-025 abort=1 in any state SHALL force IDLE next cycle with valid=0 and no done pulse; abort SHALL take priority over start and over a simultaneous transfer.
REQ-026 After a transfer, valid SHALL remain 1 with the next window (zero-bubble throughput, one window per cycle when ready=1).
REQ-027 Addresses SHALL be 13-bit unsigned; WIDTH*HEIGHT <= 8192 is a legal-configuration requirement.

Reset
REQ-028 On reset=1 the block SHALL enter IDLE and hold x=0, y=0, reference=0, out_index=0, valid=0, last=0, busy=0, done=0.
REQ-029 reset SHALL override start and abort, and reset mid-scan SHALL discard all progress.

Structure
REQ-030 The state encoding and the default WIDTH/HEIGHT constants SHALL live in the shared CNN-layer package, alongside the window offsets used by the address-offset stage.
REQ-031 The block SHALL be a single module with no sub-modules; x and y counters are internal registers.

Verification
REQ-032 The bench SHALL cover: reset, then start with ready=1 held -> first window reference=0/out_index=0; the 79th window reference=80/out_index=78.
REQ-033 The bench SHALL cover: full frame with ready=1 -> 4524 transfers; the last has reference=4637, out_index=4523, last=1; done pulses once the next cycle; busy=0 after that.
REQ-034 The bench SHALL cover: ready deasserted for 5 cycles at window reference=77 -> reference, out_index and valid held; the next transfer yields reference=80.
REQ-035 The bench SHALL cover: abort asserted mid-row at reference=200 with ready=1 -> valid=0 next cycle, no done; a new start restarts at reference=0.
REQ-036 The bench SHALL cover: start pulsed during SCAN -> no effect on the sequence; reset asserted mid-scan -> all outputs at reset values next cycle.
REQ-037 The bench SHALL cover: random ready throttling over a full frame -> the sequence matches the reference model y*WIDTH+x, with no duplicates and no gaps.
